// File: rtl/data_mem_unit.sv
// Load/store stage: runs a req/ack data-memory transaction, formats byte/half/word
// lanes and stalls the core until the access completes or times out.
module data_mem_unit #(
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        stall_o,
  output logic        access_fault_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int unsigned CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLimit = CntW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            we_q, we_d;
  logic [31:0]     read_data_q, read_data_d;

  logic        req;
  logic        fault;
  logic        in_idle;
  logic        in_access;
  logic [31:0] load_fmt;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;

  assign req       = mem_read_i | mem_write_i;
  assign in_idle   = (state_q == StIdle);
  assign in_access = (state_q == StAccess);

  // Request validity: unsupported size, misalignment, or unsigned store.
  always_comb begin
    fault = 1'b0;
    case (funct3_i)
      3'b000:  fault = 1'b0;
      3'b001:  fault = alu_result_i[0];
      3'b010:  fault = (alu_result_i[1:0] != 2'b00);
      3'b100:  fault = mem_write_i;
      3'b101:  fault = mem_write_i | alu_result_i[0];
      default: fault = 1'b1;
    endcase
  end

  // Load lane extraction from the latched address and size.
  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel = bus_rdata_i[8*addr_q[1:0] +: 8];
    half_sel = addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (funct3_q[1:0])
      2'b00:   load_fmt = {{24{byte_sel[7] & ~funct3_q[2]}}, byte_sel};
      2'b01:   load_fmt = {{16{half_sel[15] & ~funct3_q[2]}}, half_sel};
      default: load_fmt = bus_rdata_i;
    endcase
  end

  // Store byte enables and lane replication from the latched request.
  always_comb begin
    store_be    = 4'b0000;
    store_wdata = 32'h0;
    case (funct3_q[1:0])
      2'b00: begin
        store_be    = 4'b0001 << addr_q[1:0];
        store_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        store_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        store_be    = 4'b1111;
        store_wdata = wdata_q;
      end
      default: begin
        store_be    = 4'b0000;
        store_wdata = 32'h0;
      end
    endcase
  end

  // Next-state logic for the access FSM, timeout counter and load result.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    we_d        = we_q;
    read_data_d = read_data_q;
    bus_err_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req && !fault) begin
          addr_d   = alu_result_i;
          wdata_d  = write_data_i;
          funct3_d = funct3_i;
          we_d     = mem_write_i;
          cnt_d    = '0;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        if (bus_ack_i) begin
          if (!we_q) read_data_d = load_fmt;
          state_d = StDone;
        end else if (cnt_q == CntLimit) begin
          bus_err_o   = 1'b1;
          read_data_d = 32'h0;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        // Request is deliberately not sampled here so the instruction retires once.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      funct3_q    <= 3'b000;
      we_q        <= 1'b0;
      read_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      we_q        <= we_d;
      read_data_q <= read_data_d;
    end
  end

  // Bus and core-facing outputs; reset forces the combinational ones low.
  always_comb begin
    read_data_o    = read_data_q;
    stall_o        = ~rst_i & ((in_idle & req & ~fault) | in_access);
    access_fault_o = ~rst_i & in_idle & req & fault;
    bus_req_o      = in_access;
    bus_we_o       = in_access & we_q;
    bus_addr_o     = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
    bus_be_o       = in_access ? (we_q ? store_be : 4'b1111) : 4'b0000;
    bus_wdata_o    = (in_access && we_q) ? store_wdata : 32'h0;
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: loads, stores, faults, timeout and async reset.
module tb_data_mem_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_result_i, write_data_i;
  logic [31:0] read_data_o;
  logic        stall_o, access_fault_o, bus_err_o, bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  int n_checks = 0;
  int n_fails  = 0;

  data_mem_unit #(.TimeoutCycles(16)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mem_read_i    (mem_read_i),
    .mem_write_i   (mem_write_i),
    .funct3_i      (funct3_i),
    .alu_result_i  (alu_result_i),
    .write_data_i  (write_data_i),
    .read_data_o   (read_data_o),
    .stall_o       (stall_o),
    .access_fault_o(access_fault_o),
    .bus_err_o     (bus_err_o),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_addr_o    (bus_addr_o),
    .bus_be_o      (bus_be_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_ack_i     (bus_ack_i),
    .bus_rdata_i   (bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Load with a zero-wait slave; also checks DONE ignores a still-asserted request.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = f3; alu_result_i = addr;
    #1;
    check("ld_idle_stall", 32'(stall_o), 32'd1);
    check("ld_idle_req", 32'(bus_req_o), 32'd0);
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = rdata;
    #1;
    check("ld_acc_req", 32'(bus_req_o), 32'd1);
    check("ld_acc_stall", 32'(stall_o), 32'd1);
    check("ld_acc_we", 32'(bus_we_o), 32'd0);
    check("ld_acc_addr", bus_addr_o, {addr[31:2], 2'b00});
    check("ld_acc_be", 32'(bus_be_o), 32'hF);
    tick();
    bus_ack_i = 1'b0;
    #1;
    check("ld_done_stall", 32'(stall_o), 32'd0);
    check("ld_done_req", 32'(bus_req_o), 32'd0);
    check("ld_data", read_data_o, exp);
    mem_read_i = 1'b0;
    tick();
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd);
    mem_read_i = 1'b0; mem_write_i = 1'b1; funct3_i = f3; alu_result_i = addr;
    write_data_i = wd;
    #1;
    check("st_idle_stall", 32'(stall_o), 32'd1);
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_5555;
    #1;
    check("st_acc_req", 32'(bus_req_o), 32'd1);
    check("st_acc_we", 32'(bus_we_o), 32'd1);
    check("st_acc_addr", bus_addr_o, {addr[31:2], 2'b00});
    check("st_acc_be", 32'(bus_be_o), 32'(exp_be));
    check("st_acc_wdata", bus_wdata_o, exp_wd);
    tick();
    bus_ack_i = 1'b0;
    #1;
    check("st_done_stall", 32'(stall_o), 32'd0);
    check("st_keeps_rdata", read_data_o, exp_rd);
    mem_write_i = 1'b0;
    tick();
  endtask

  task automatic do_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    mem_read_i = ~we; mem_write_i = we; funct3_i = f3; alu_result_i = addr;
    #1;
    check("flt_pulse", 32'(access_fault_o), 32'd1);
    check("flt_stall", 32'(stall_o), 32'd0);
    check("flt_req", 32'(bus_req_o), 32'd0);
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    tick();
    check("flt_pulse_end", 32'(access_fault_o), 32'd0);
    check("flt_still_idle", 32'(bus_req_o), 32'd0);
  endtask

  // Slow slave: ack_cyc 0 = never acks, 16 = acks on the limit cycle.
  task automatic do_slow(input logic we, input int ack_cyc, input logic [31:0] rdata,
                         input logic [31:0] exp_rd);
    mem_read_i = ~we; mem_write_i = we; funct3_i = 3'b010; alu_result_i = 32'h300;
    write_data_i = 32'h1234_5678;
    tick();
    for (int c = 1; c <= 16; c++) begin
      bus_ack_i = (c == ack_cyc); bus_rdata_i = rdata;
      #1;
      check("slow_req", 32'(bus_req_o), 32'd1);
      check("slow_stall", 32'(stall_o), 32'd1);
      check("slow_err", 32'(bus_err_o), 32'((c == 16) && (ack_cyc == 0)));
      if (c < 16) tick();
    end
    tick();
    bus_ack_i = 1'b0;
    #1;
    check("slow_done_stall", 32'(stall_o), 32'd0);
    check("slow_done_req", 32'(bus_req_o), 32'd0);
    check("slow_done_err", 32'(bus_err_o), 32'd0);
    check("slow_rdata", read_data_o, exp_rd);
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    tick();
    check("slow_back_idle", 32'(bus_req_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b000;
    alu_result_i = 32'h0; write_data_i = 32'h0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_rdata", read_data_o, 32'h0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_req", 32'(bus_req_o), 32'd0);
    check("rst_be", 32'(bus_be_o), 32'd0);
    rst_i = 1'b0;
    tick();

    do_load(3'b010, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load(3'b000, 32'h103, 32'h8011_2233, 32'hFFFF_FF80);
    do_load(3'b100, 32'h103, 32'h8011_2233, 32'h0000_0080);
    do_load(3'b001, 32'h102, 32'h8001_7FFF, 32'hFFFF_8001);
    do_load(3'b101, 32'h100, 32'h8001_F00F, 32'h0000_F00F);
    do_load(3'b000, 32'h101, 32'h0000_7F00, 32'h0000_007F);

    do_store(3'b001, 32'h202, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD, 32'h0000_007F);
    do_store(3'b000, 32'h201, 32'hFFFF_FF5A, 4'b0010, 32'h5A5A_5A5A, 32'h0000_007F);
    do_store(3'b010, 32'h204, 32'h0BAD_CAFE, 4'b1111, 32'h0BAD_CAFE, 32'h0000_007F);

    do_fault(1'b0, 3'b010, 32'h101);
    do_fault(1'b0, 3'b001, 32'h103);
    do_fault(1'b1, 3'b100, 32'h200);
    do_fault(1'b0, 3'b011, 32'h200);

    do_slow(1'b0, 16, 32'h1357_9BDF, 32'h1357_9BDF);
    do_slow(1'b1, 0, 32'h0, 32'h0);

    // Reset during an ACCESS wait, then a stray ACK afterwards.
    do_load(3'b010, 32'h104, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    mem_read_i = 1'b1; funct3_i = 3'b010; alu_result_i = 32'h400;
    tick();
    tick();
    check("rstmid_req_before", 32'(bus_req_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("rstmid_req", 32'(bus_req_o), 32'd0);
    check("rstmid_stall", 32'(stall_o), 32'd0);
    check("rstmid_rdata", read_data_o, 32'h0);
    mem_read_i = 1'b0;
    tick();
    rst_i = 1'b0;
    bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
    #1;
    check("late_ack_req", 32'(bus_req_o), 32'd0);
    check("late_ack_stall", 32'(stall_o), 32'd0);
    tick();
    bus_ack_i = 1'b0;
    #1;
    check("late_ack_rdata", read_data_o, 32'h0);
    check("late_ack_idle", 32'(bus_req_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
